// File: rtl/vm_pkg.sv
// vm_pkg: definitions shared by the vending-machine front end.
//   DOL_* : 2-bit credit codes carried on the dol bus to the vending FSM.
//   deb_state_t : per-channel coin debounce state.
package vm_pkg;

  localparam logic [1:0] DOL_NONE  = 2'd0;
  localparam logic [1:0] DOL_ONE   = 2'd1;
  localparam logic [1:0] DOL_TWO   = 2'd2;
  localparam logic [1:0] DOL_THREE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } deb_state_t;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: synchronises and debounces one raw coin-sensor line.
//
// State table:
//   state   | meaning
//   IDLE    | no coin present; waiting for the synchronised line to rise
//   ARMING  | line high, counting stable high samples toward acceptance
//   HELD    | coin accepted (or present since reset); no further events
//   RELEASE | line low, counting stable low samples toward IDLE
//
// Ports:
//   clk   in  clock
//   reset in  asynchronous, active-high; clears all state
//   raw   in  asynchronous sensor line, high = coin present
//   ev    out registered one-cycle pulse when a press is accepted
//
// The counter runs down: it is loaded with DEBOUNCE_CYCLES-1 on entry to
// ARMING/RELEASE and the state completes when a further matching sample
// arrives with the counter at 1.
module coin_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic ev
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(1);

  logic             sync_q1;
  logic             sync_q2;
  logic [1:0]       live_q;
  logic             ready_q;
  logic             ready_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ev_d;
  deb_state_t       state_q;
  deb_state_t       state_d;

  logic sync;
  logic live;

  assign sync = sync_q2;
  // The synchroniser output is a reset artefact for the first two edges
  // after reset release; live marks when it reflects a real sample.
  assign live = live_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      live_q  <= 2'b00;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      ev      <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      live_q  <= {live_q[0], 1'b1};
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      ev      <= ev_d;
      state_q <= state_d;
    end
  end

  // Until the line has been seen low for a full debounce window after
  // reset (ready_q), a high line is treated as an already-held coin so a
  // sensor stuck high through reset never produces credit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (live) begin
          if (sync)         state_d = ready_q ? ARMING : HELD;
          else if (!ready_q) state_d = RELEASE;
        end
      end
      ARMING: begin
        if (!sync)                 state_d = IDLE;
        else if (cnt_q == CNT_TERM) state_d = HELD;
      end
      HELD: begin
        if (!sync) state_d = RELEASE;
      end
      RELEASE: begin
        if (sync)                  state_d = HELD;
        else if (cnt_q == CNT_TERM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    ev_d    = 1'b0;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (live) begin
          if (sync)          cnt_d = ready_q ? CNT_LOAD : '0;
          else if (!ready_q) cnt_d = CNT_LOAD;
        end
      end
      ARMING: begin
        if (!sync) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
          cnt_d = '0;
          ev_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync) cnt_d = CNT_LOAD;
      end
      RELEASE: begin
        if (sync) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: turns the $1/$2 coin sensor lines into the 2-bit dol
// credit code for the vending FSM.
//
// Ports:
//   clk          in  clock
//   reset        in  asynchronous, active-high
//   coin1_raw    in  $1 slot sensor (asynchronous)
//   coin2_raw    in  $2 slot sensor (asynchronous)
//   vend_in      in  vending FSM change output; credit is held while high
//   dol          out registered credit code 0..3, one cycle per emission
//   coin_reject  out registered pulse when summed credit exceeded 3
//   credit_total out running dollar count on dol
//
// Build option: define COIN_ACCEPTOR_COUNT_EN to build the 16-bit
// credit_total counter; otherwise credit_total is tied to zero.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin1_raw,
  input  logic        coin2_raw,
  input  logic        vend_in,
  output logic [1:0]  dol,
  output logic        coin_reject,
  output logic [15:0] credit_total
);

  logic       ev1;
  logic       ev2;
  logic [1:0] pend_q;
  logic [2:0] sum;
  logic       over;
  logic [1:0] sat;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb1 (
    .clk   (clk),
    .reset (reset),
    .raw   (coin1_raw),
    .ev    (ev1)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb2 (
    .clk   (clk),
    .reset (reset),
    .raw   (coin2_raw),
    .ev    (ev2)
  );

  always_comb begin
    sum  = {1'b0, pend_q}
         + (ev1 ? {1'b0, DOL_ONE} : 3'd0)
         + (ev2 ? {1'b0, DOL_TWO} : 3'd0);
    over = (sum > 3'd3);
    sat  = over ? DOL_THREE : sum[1:0];
  end

  // While the FSM is vending it ignores dol, so credit is parked in pend
  // and released on the first cycle with vend_in low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dol         <= DOL_NONE;
      pend_q      <= DOL_NONE;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= over;
      if (vend_in) begin
        dol    <= DOL_NONE;
        pend_q <= sat;
      end else begin
        dol    <= sat;
        pend_q <= DOL_NONE;
      end
    end
  end

`ifdef COIN_ACCEPTOR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) credit_total <= 16'd0;
    else       credit_total <= credit_total + {14'd0, dol};
  end
`else
  assign credit_total = 16'd0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed bench for coin_acceptor with DEBOUNCE_CYCLES=4.
// Expected dol values and reject pulses are queued when a coin is driven and
// consumed by a negedge monitor whenever the DUT presents them; directed
// checks pin down the exact cycle of each emission.
module tb_coin_acceptor;

  localparam int D = 4;
`ifdef COIN_ACCEPTOR_COUNT_EN
  localparam int CREDIT_ON = 1;
`else
  localparam int CREDIT_ON = 0;
`endif

  logic        clk;
  logic        reset;
  logic        coin1_raw;
  logic        coin2_raw;
  logic        vend_in;
  logic [1:0]  dol;
  logic        coin_reject;
  logic [15:0] credit_total;

  int checks = 0;
  int errors = 0;

  logic [1:0]  dq[$];
  logic        rq[$];
  logic [15:0] exp_credit = 16'd0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin1_raw    (coin1_raw),
    .coin2_raw    (coin2_raw),
    .vend_in      (vend_in),
    .dol          (dol),
    .coin_reject  (coin_reject),
    .credit_total (credit_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e_dol;
    logic       e_rej;
    if (reset) begin
      exp_credit = 16'd0;
    end else begin
      chk("credit", credit_total, exp_credit);
      if (dol !== 2'd0) begin
        e_dol = (dq.size() > 0) ? dq.pop_front() : 2'd0;
        chk("sb_dol", {14'd0, dol}, {14'd0, e_dol});
        if (CREDIT_ON != 0) exp_credit = exp_credit + {14'd0, e_dol};
      end
      if (coin_reject !== 1'b0) begin
        e_rej = (rq.size() > 0) ? rq.pop_front() : 1'b0;
        chk("sb_rej", {15'd0, coin_reject}, {15'd0, e_rej});
      end
    end
  end

  initial begin
    reset     = 1'b1;
    coin1_raw = 1'b0;
    coin2_raw = 1'b0;
    vend_in   = 1'b0;
    step(3);
    chk("rst_dol", {14'd0, dol}, 16'd0);
    chk("rst_rej", {15'd0, coin_reject}, 16'd0);
    chk("rst_credit", credit_total, 16'd0);
    reset = 1'b0;
    step(10);

    // $1 coin held 10 cycles: dol=1 after the 6th edge, once
    coin1_raw = 1'b1;
    dq.push_back(2'd1);
    step(6);
    chk("t1_early", {14'd0, dol}, 16'd0);
    step(1);
    chk("t1_dol", {14'd0, dol}, 16'd1);
    step(1);
    chk("t1_once", {14'd0, dol}, 16'd0);
    step(2);
    coin1_raw = 1'b0;
    step(8);
    chk("t1_credit", credit_total, 16'(CREDIT_ON));

    // glitchy $2 line, then a clean 5-cycle press
    for (int i = 0; i < 3; i++) begin
      coin2_raw = 1'b1;
      step(3);
      coin2_raw = 1'b0;
      step(1);
    end
    chk("t2_glitch", {14'd0, dol}, 16'd0);
    coin2_raw = 1'b1;
    dq.push_back(2'd2);
    step(5);
    coin2_raw = 1'b0;
    step(2);
    chk("t2_dol", {14'd0, dol}, 16'd2);
    step(1);
    chk("t2_once", {14'd0, dol}, 16'd0);
    step(8);

    // simultaneous coins sum to 3 without reject
    coin1_raw = 1'b1;
    coin2_raw = 1'b1;
    dq.push_back(2'd3);
    step(7);
    chk("t3_dol", {14'd0, dol}, 16'd3);
    chk("t3_rej_same", {15'd0, coin_reject}, 16'd0);
    step(1);
    chk("t3_rej", {15'd0, coin_reject}, 16'd0);
    chk("t3_once", {14'd0, dol}, 16'd0);
    coin1_raw = 1'b0;
    coin2_raw = 1'b0;
    step(8);

    // $2 event in a vend cycle is held one cycle
    coin2_raw = 1'b1;
    dq.push_back(2'd2);
    step(6);
    vend_in = 1'b1;
    step(1);
    chk("t4_block", {14'd0, dol}, 16'd0);
    vend_in = 1'b0;
    step(1);
    chk("t4_hold", {14'd0, dol}, 16'd2);
    step(1);
    chk("t4_once", {14'd0, dol}, 16'd0);
    coin2_raw = 1'b0;
    step(8);

    // pend=2 held over a long vend; a second $2 saturates pend and rejects
    coin2_raw = 1'b1;
    step(6);
    vend_in = 1'b1;
    step(1);
    chk("t5_block1", {14'd0, dol}, 16'd0);
    coin2_raw = 1'b0;
    step(8);
    coin2_raw = 1'b1;
    dq.push_back(2'd3);
    rq.push_back(1'b1);
    step(6);
    chk("t5_block2", {14'd0, dol}, 16'd0);
    chk("t5_rej_early", {15'd0, coin_reject}, 16'd0);
    step(1);
    chk("t5_rej", {15'd0, coin_reject}, 16'd1);
    chk("t5_block3", {14'd0, dol}, 16'd0);
    vend_in = 1'b0;
    step(1);
    chk("t5_dol", {14'd0, dol}, 16'd3);
    chk("t5_rej_once", {15'd0, coin_reject}, 16'd0);
    coin2_raw = 1'b0;
    step(8);

    // reset while arming with the $1 line held high
    coin1_raw = 1'b1;
    step(3);
    reset = 1'b1;
    step(2);
    chk("rst2_dol", {14'd0, dol}, 16'd0);
    chk("rst2_rej", {15'd0, coin_reject}, 16'd0);
    chk("rst2_credit", credit_total, 16'd0);
    reset = 1'b0;
    step(20);
    chk("t6_quiet", {14'd0, dol}, 16'd0);
    coin1_raw = 1'b0;
    step(8);
    coin1_raw = 1'b1;
    dq.push_back(2'd1);
    step(7);
    chk("t6_dol", {14'd0, dol}, 16'd1);
    step(1);
    chk("t6_once", {14'd0, dol}, 16'd0);
    coin1_raw = 1'b0;
    step(8);
    chk("t6_credit", credit_total, 16'(CREDIT_ON));

    chk("sb_dol_left", 16'(dq.size()), 16'd0);
    chk("sb_rej_left", 16'(rq.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that turns the two raw coin-sensor lines ($1 slot, $2 slot) into the 2-bit `dol` credit code consumed by the vending FSM. Each line is synchronised and debounced. Coin events landing in the same cycle are summed. Credit is held back during the cycle in which the vending FSM ignores input, so no coin is lost.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a press or a release; legal range 2..2^CNT_W-1.
- `CNT_W`, default 5: debounce counter width.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `coin1_raw`  in  1: $1 slot sensor, asynchronous, high = coin present.
- `coin2_raw`  in  1: $2 slot sensor, asynchronous, high = coin present.
- `vend_in`  in  1: `change` output of the vending FSM; high means the FSM is in the vend state on the next cycle.
- `dol`  out  2: registered credit code for the vending FSM, 0..3; non-zero for exactly one cycle per emission.
- `coin_reject`  out  1: registered one-cycle pulse when summed credit exceeds 3.
- `credit_total`  out  16: running count of dollars delivered on `dol` (see Configuration).

## Operation
- Per channel, a 2-flop synchroniser feeds a debounce FSM with states IDLE, ARMING, HELD and RELEASE:
  - IDLE: sync=1 → ARMING, count=1.
  - ARMING: sync=1 → count+1; when count reaches DEBOUNCE_CYCLES → HELD and emit a one-cycle event. sync=0 → IDLE, count=0.
  - HELD: sync=0 → RELEASE, count=1. Held coins produce no further events.
  - RELEASE: sync=0 → count+1; when count reaches DEBOUNCE_CYCLES → IDLE. sync=1 → HELD, count=0.
- Event value: channel 1 = 1, channel 2 = 2. Each cycle, sum = pend + ev1 + ev2, computed 3 bits wide.
- If sum > 3: the 2-bit result saturates to 3, and `coin_reject` is pulsed on the next cycle.
- Emission rule, evaluated each clock edge:
  - If vend_in=1: dol ← 0 and pend ← sat(sum). Credit is held over the FSM's vend cycle.
  - Else: dol ← sat(sum) and pend ← 0.
- pend never exceeds 3. dol is never non-zero in the cycle after vend_in=1.
- Reset values:
  - Outputs: dol=0, coin_reject=0, credit_total=0.
  - Internal: pend=0, both channels IDLE, counters 0, synchronisers 0.
- Reset mid-debounce or with pend≠0 discards the partial or pending credit. No event is generated on reset release, even if a raw line is held high.

## Timing
- Latency: raw rising edge first sampled at edge E0 → event registered after edge E(DEBOUNCE_CYCLES+1) → dol valid in the cycle after edge E(DEBOUNCE_CYCLES+2).
- Held-over credit appears on dol one cycle after the blocked cycle, provided vend_in=0 in that cycle.
- Consecutive vend_in=1 cycles extend the hold. Events during the hold accumulate into pend, with saturation.
- Minimum spacing between two accepted coins on one channel: 2·DEBOUNCE_CYCLES cycles.
- Simultaneous ev1 and ev2 produce a single dol=3.

## Configuration
- `COIN_ACCEPTOR_COUNT_EN` defined: credit_total is a 16-bit counter incremented by the dol value every cycle; it wraps modulo 2^16 and is cleared by reset.
- Not defined: credit_total is tied to 0 and no counter logic is built. The port is always present.

## Structure
- Shared package `vm_pkg`: DOL_NONE/DOL_ONE/DOL_TWO/DOL_THREE constants, and the debounce state typedef (IDLE/ARMING/HELD/RELEASE).
- Sub-module `coin_debounce`, instantiated once per channel. It contains the synchroniser, counter and FSM, has parameters DEBOUNCE_CYCLES and CNT_W, and outputs a one-cycle `event` pulse. The summing, hold and reject logic sits in the top module.

## Test plan
- DEBOUNCE_CYCLES=4; coin1_raw high for 10 cycles → dol=1 for exactly one cycle, 6 edges after E0; credit_total=1 with the macro defined.
- coin2_raw toggling high 3 cycles / low 1 cycle (glitchy) → no event. Then high for 5 cycles → a single dol=2.
- coin1_raw and coin2_raw rising on the same edge → one dol=3, coin_reject=0.
- vend_in=1 in the cycle a $2 event occurs → dol=0 in the next cycle, then dol=2 in the following cycle.
- pend=2 held by vend_in=1, then a $2 event during a second vend_in=1 cycle → pend saturates to 3, coin_reject pulses, and dol=3 appears once vend_in drops.
- reset asserted while in ARMING with coin1_raw held high → dol stays 0 and no event after reset release, until coin1_raw goes low for DEBOUNCE_CYCLES and rises again.
